// File: rtl/audio_fft_pkg.sv
// audio_fft_pkg: shared constants and read-FSM encoding for the audio FFT framer
package audio_fft_pkg;
  localparam int FFT_W = 10;
  localparam int DATA_W = 16;
  localparam int N = 1 << FFT_W;
  localparam logic FWD = 1'b1;
  localparam logic INV = 1'b0;
  typedef enum logic [1:0] {IDLE, CFG, STREAM, DONE} state_e;
endpackage

// File: rtl/framer_pingpong_ram.sv
// framer_pingpong_ram: two-bank sample store, one write port and one registered read port
module framer_pingpong_ram
  import audio_fft_pkg::*;
#(
  parameter int AW = FFT_W + 1,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/audio_fft_framer.sv
// audio_fft_framer: collects audio samples into ping-pong frames and streams them to an AXI4-Stream FFT
module audio_fft_framer
  import audio_fft_pkg::*;
#(
  parameter int   FFT_WIDTH  = FFT_W,
  parameter int   DATA_WIDTH = DATA_W,
  parameter logic FFT_MODE   = FWD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  audio_valid,
  input  logic [DATA_WIDTH-1:0] audio_data,
  output logic                  xn_axi4s_cfg_tvalid,
  output logic                  xn_axi4s_cfg_tdata,
  input  logic                  xn_axi4s_cfg_tready,
  output logic                  xn_axi4s_data_tvalid,
  output logic [31:0]           xn_axi4s_data_tdata,
  output logic                  xn_axi4s_data_tlast,
  input  logic                  xn_axi4s_data_tready,
  output logic                  overflow,
  output logic                  frame_done
);
  state_e state, state_d;
  logic [1:0] bank_full, set_mask, clr_mask, occ, wi;
  logic wr_bank, rd_bank, wr_en, issue, pend, pend_last, pop;
  logic [FFT_WIDTH-1:0] wr_ptr;
  logic [FFT_WIDTH:0] rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH:0] skid [2];
  framer_pingpong_ram #(.AW(FFT_WIDTH + 1), .DW(DATA_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank, wr_ptr}),
    .wdata (audio_data),
    .raddr ({rd_bank, rd_ptr[FFT_WIDTH-1:0]}),
    .rdata (rd_data)
  );
  assign wr_en = audio_valid && !bank_full[wr_bank];
  assign pop = xn_axi4s_data_tvalid && xn_axi4s_data_tready;
  // occupancy plus the read in flight never exceeds the two skid slots
  assign issue = state == STREAM && !rd_ptr[FFT_WIDTH] && (occ + {1'b0, pend} - {1'b0, pop}) < 2'd2;
  assign wi = occ - {1'b0, pop};
  assign xn_axi4s_data_tvalid = occ != 2'd0;
  assign xn_axi4s_data_tlast = skid[0][DATA_WIDTH];
  assign xn_axi4s_data_tdata = {{(32-DATA_WIDTH){1'b0}}, skid[0][DATA_WIDTH-1:0]};
  assign set_mask = (wr_en && &wr_ptr) ? 2'b01 << wr_bank : 2'b00;
  assign clr_mask = (state == DONE) ? 2'b01 << rd_bank : 2'b00;
  always_comb begin
    state_d = state;
    xn_axi4s_cfg_tvalid = 1'b0;
    xn_axi4s_cfg_tdata = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: state_d = bank_full[rd_bank] ? CFG : IDLE;
      CFG: begin
        xn_axi4s_cfg_tvalid = 1'b1;
        xn_axi4s_cfg_tdata = FFT_MODE;
        state_d = xn_axi4s_cfg_tready ? STREAM : CFG;
      end
      STREAM: state_d = (pop && xn_axi4s_data_tlast) ? DONE : STREAM;
      DONE: begin
        frame_done = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bank_full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      occ <= '0;
      skid[0] <= '0;
      skid[1] <= '0;
    end else begin
      state <= state_d;
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      overflow <= overflow | (audio_valid && bank_full[wr_bank]);
      if (wr_en) wr_ptr <= wr_ptr + FFT_WIDTH'(1);
      if (wr_en && &wr_ptr) wr_bank <= !wr_bank;
      if (state == DONE) rd_bank <= !rd_bank;
      if (state == CFG) rd_ptr <= '0;
      else if (issue) rd_ptr <= rd_ptr + (FFT_WIDTH + 1)'(1);
      pend <= issue;
      pend_last <= issue && &rd_ptr[FFT_WIDTH-1:0];
      occ <= occ + {1'b0, pend} - {1'b0, pop};
      if (pop) skid[0] <= skid[1];
      if (pend) skid[wi[0]] <= {pend_last, rd_data};
    end
  end
endmodule
